// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: 16-bit instructions executed through a FETCH/EXEC/MEM state machine over one
// shared single-port memory. Defining MULTICYCLE_CPU_MUL_EN turns opcode 0xD into an unsigned MUL.
module multicycle_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_N  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_out,
  output logic              rw_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HLT} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SLT,
    OP_ADDI, OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_MUL, OP_NOP, OP_HALT
  } op_t;

  state_t            state;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [REG_N];

  op_t               op;
  logic [2:0]        rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0] rd_val, rs1_val, rs2_val, imm;
  logic              rd_ok;
  logic [ADDR_W-1:0] eff_addr, next_pc;
  logic [DATA_W-1:0] exec_res;
  logic              exec_wr;

  assign op      = op_t'(ir[15:12]);
  assign rd_idx  = ir[11:9];
  assign rs1_idx = ir[8:6];
  assign rs2_idx = ir[5:3];
  assign imm     = {{(DATA_W-6){ir[5]}}, ir[5:0]};

  // r0 and indices beyond REG_N read as zero and swallow writes.
  assign rd_val  = (rd_idx  != 3'd0 && int'(rd_idx)  < REG_N) ? regs[rd_idx]  : '0;
  assign rs1_val = (rs1_idx != 3'd0 && int'(rs1_idx) < REG_N) ? regs[rs1_idx] : '0;
  assign rs2_val = (rs2_idx != 3'd0 && int'(rs2_idx) < REG_N) ? regs[rs2_idx] : '0;
  assign rd_ok   = (rd_idx != 3'd0) && (int'(rd_idx) < REG_N);

  assign eff_addr = rs1_val[ADDR_W-1:0] + imm[ADDR_W-1:0];

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    exec_res = '0;
    exec_wr  = 1'b0;
    next_pc  = pc;
    case (op)
      OP_ADD:  begin exec_res = rs1_val + rs2_val;          exec_wr = 1'b1; end
      OP_SUB:  begin exec_res = rs1_val - rs2_val;          exec_wr = 1'b1; end
      OP_AND:  begin exec_res = rs1_val & rs2_val;          exec_wr = 1'b1; end
      OP_OR:   begin exec_res = rs1_val | rs2_val;          exec_wr = 1'b1; end
      OP_XOR:  begin exec_res = rs1_val ^ rs2_val;          exec_wr = 1'b1; end
      OP_SHL:  begin exec_res = rs1_val << rs2_val[3:0];    exec_wr = 1'b1; end
      OP_SHR:  begin exec_res = rs1_val >> rs2_val[3:0];    exec_wr = 1'b1; end
      OP_SLT:  begin
        exec_res = {{(DATA_W-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
        exec_wr  = 1'b1;
      end
      OP_ADDI: begin exec_res = rs1_val + imm;              exec_wr = 1'b1; end
      // pc already points past the branch, so the offset is applied to it directly.
      OP_BEQ:  if (rd_val == rs1_val) next_pc = pc + imm[ADDR_W-1:0];
      OP_JMP:  next_pc = ir[ADDR_W-1:0];
`ifdef MULTICYCLE_CPU_MUL_EN
      OP_MUL:  begin exec_res = rs1_val * rs2_val;          exec_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  // A write to memory happens only in the ST MEM cycle; reset drops it at once.
  assign rw_enable = !(reset && state == S_MEM && op == OP_ST);
  assign data_in   = (state == S_MEM && op == OP_ST) ? rd_val : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      address <= '0;
      halted  <= 1'b0;
      // NOTE: the register file is small and must read zero after reset, so it is reset explicitly.
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          ir    <= data_out[15:0];
          pc    <= pc + ADDR_W'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_wr && rd_ok) regs[rd_idx] <= exec_res;
          pc <= next_pc;
          if (op == OP_LD || op == OP_ST) begin
            address <= eff_addr;
            state   <= S_MEM;
          end else if (op == OP_HALT) begin
            address <= pc;
            halted  <= 1'b1;
            state   <= S_HLT;
          end else begin
            address <= next_pc;
            state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (op == OP_LD && rd_ok) regs[rd_idx] <= data_out;
          address <= pc;
          state   <= S_FETCH;
        end
        S_HLT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: table-driven ALU vectors plus hand-written bus sequences.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_out;
  logic        rw_enable;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [256];

  multicycle_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .data_out  (data_out),
    .rw_enable (rw_enable),
    .address   (address),
    .data_in   (data_in),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign data_out = mem[address];

  always @(posedge clk) if (!rw_enable) mem[address] = data_in;

  typedef struct packed {
    logic [7:0]  addr;
    logic        rw;
    logic [15:0] din;
    logic        halt;
  } smp_t;

  smp_t trace[$];
  bit   log_en = 1'b0;

  always @(negedge clk) if (log_en) trace.push_back('{address, rw_enable, data_in, halted});

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  st_rd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input int imm);
    logic [5:0] i6;
    i6 = imm[5:0];
    return {op, rd, rs1, i6};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [15:0] instr, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] st_rd, input logic [15:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.a = a; v.b = b; v.st_rd = st_rd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic hold();
    reset = 1'b0;
    #1;
    log_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_cpu();
    @(posedge clk);
    #2;
    trace.delete();
    log_en = 1'b1;
    reset  = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(name, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    int n;

    #3;
    check("reset_address", address, 0);
    check("reset_rw", rw_enable, 1);
    check("reset_data_in", data_in, 0);
    check("reset_halted", halted, 0);

    // Operands come from 0xE0/0xE1, the result is stored to 0xF0, then HALT.
    add_vec("add",      enc_r(4'h0, 3, 1, 2), 16'h1234, 16'h0FF0, 3, 16'h2224);
    add_vec("sub",      enc_r(4'h1, 3, 1, 2), 16'h0005, 16'h0007, 3, 16'hFFFE);
    add_vec("and",      enc_r(4'h2, 3, 1, 2), 16'hF0F0, 16'h3C3C, 3, 16'h3030);
    add_vec("or",       enc_r(4'h3, 3, 1, 2), 16'hF0F0, 16'h0F01, 3, 16'hFFF1);
    add_vec("xor",      enc_r(4'h4, 3, 1, 2), 16'hAAAA, 16'hFFFF, 3, 16'h5555);
    add_vec("shl",      enc_r(4'h5, 3, 1, 2), 16'h0001, 16'h0013, 3, 16'h0008);
    add_vec("shr",      enc_r(4'h6, 3, 1, 2), 16'h8000, 16'h000F, 3, 16'h0001);
    add_vec("slt_neg",  enc_r(4'h7, 3, 1, 2), 16'hFFFF, 16'h0001, 3, 16'h0001);
    add_vec("slt_pos",  enc_r(4'h7, 3, 1, 2), 16'h0001, 16'hFFFF, 3, 16'h0000);
    add_vec("addi_m1",  enc_i(4'h8, 3, 1, -1), 16'h0000, 16'h0000, 3, 16'hFFFF);
    add_vec("addi_ovf", enc_i(4'h8, 3, 1, 1),  16'h7FFF, 16'h0000, 3, 16'h8000);
    add_vec("r0_write", enc_i(4'h8, 0, 1, 5),  16'h0010, 16'h0000, 0, 16'h0000);
    add_vec("r0_read",  enc_r(4'h0, 3, 0, 2), 16'h1111, 16'h0042, 3, 16'h0042);
    add_vec("nop_e",    enc_r(4'hE, 3, 1, 2), 16'h0001, 16'h0002, 3, 16'h0000);
`ifdef MULTICYCLE_CPU_MUL_EN
    add_vec("mul",      enc_r(4'hD, 3, 1, 2), 16'h0100, 16'h0101, 3, 16'h0100);
`else
    add_vec("mul_nop",  enc_r(4'hD, 3, 1, 2), 16'h0100, 16'h0101, 3, 16'h0000);
`endif

    foreach (vecs[k]) begin
      hold();
      mem[0]    = enc_i(4'h9, 1, 0, -32);
      mem[1]    = enc_i(4'h9, 2, 0, -31);
      mem[2]    = vecs[k].instr;
      mem[3]    = enc_i(4'hA, vecs[k].st_rd, 0, -16);
      mem[4]    = 16'hF000;
      mem[8'hE0] = vecs[k].a;
      mem[8'hE1] = vecs[k].b;
      mem[8'hF0] = 16'hDEAD;
      release_cpu();
      wait_halt($sformatf("%s_halt", vecs[k].name), 40);
      check(vecs[k].name, mem[8'hF0], vecs[k].exp);
    end

    // Two ADDIs back to back: fetch/exec address pattern and register forwarding.
    hold();
    mem[0] = 16'h8205;
    mem[1] = 16'h8443;
    mem[2] = enc_i(4'hA, 1, 0, -16);
    mem[3] = enc_i(4'hA, 2, 0, -15);
    mem[4] = 16'hF000;
    release_cpu();
    run(4);
    check("seq_addr0", trace[0].addr, 8'h00);
    check("seq_addr1", trace[1].addr, 8'h00);
    check("seq_addr2", trace[2].addr, 8'h01);
    check("seq_addr3", trace[3].addr, 8'h01);
    check("seq_first_rw", trace[0].rw, 1);
    wait_halt("seq_halt", 40);
    check("seq_r1", mem[8'hF0], 16'h0005);
    check("seq_r2", mem[8'hF1], 16'h0008);

    // ST then LD through base 0x40 + 2.
    hold();
    mem[0] = enc_i(4'h9, 1, 0, -32);
    mem[1] = enc_i(4'h9, 2, 0, -31);
    mem[2] = 16'hA282;
    mem[3] = 16'h9682;
    mem[4] = enc_i(4'hA, 3, 0, -16);
    mem[5] = 16'hF000;
    mem[8'hE0] = 16'h00AB;
    mem[8'hE1] = 16'h0040;
    release_cpu();
    run(13);
    check("st_rw", trace[8].rw, 0);
    check("st_addr", trace[8].addr, 8'h42);
    check("st_data", trace[8].din, 16'h00AB);
    check("st_data_after", trace[9].din, 16'h0000);
    check("ld_mem_addr", trace[11].addr, 8'h42);
    check("ld_next_fetch", trace[12].addr, 8'h04);
    writes = 0;
    for (int i = 0; i < 13; i++) if (!trace[i].rw) writes++;
    check("st_single_write", writes, 1);
    wait_halt("stld_halt", 40);
    check("st_mem", mem[8'h42], 16'h00AB);
    check("ld_value", mem[8'hF0], 16'h00AB);

    // Reset asserted in the middle of the ST MEM cycle.
    hold();
    mem[0] = enc_i(4'h9, 1, 0, -32);
    mem[1] = enc_i(4'h9, 2, 0, -31);
    mem[2] = 16'hA282;
    mem[8'hE0] = 16'h00AB;
    mem[8'hE1] = 16'h0040;
    release_cpu();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rw_enable && n < 30);
    check("st_seen_before_reset", rw_enable, 0);
    reset = 1'b0;
    #1;
    check("reset_in_st_rw", rw_enable, 1);
    check("reset_in_st_data", data_in, 0);

    // Taken BEQ self-loop at 0x10.
    hold();
    mem[0]     = 16'hC010;
    mem[8'h10] = enc_i(4'hB, 1, 1, -1);
    release_cpu();
    run(10);
    check("beq_loop_a", trace[4].addr, 8'h10);
    check("beq_loop_b", trace[6].addr, 8'h10);
    check("beq_loop_c", trace[8].addr, 8'h10);
    check("beq_loop_halt", trace[9].halt, 0);

    // BEQ not taken falls through to 0x11.
    hold();
    mem[0]     = 16'h8201;
    mem[1]     = 16'hC010;
    mem[8'h10] = enc_i(4'hB, 1, 0, -1);
    mem[8'h11] = 16'hF000;
    release_cpu();
    run(8);
    check("beq_nt_exec", trace[5].addr, 8'h10);
    check("beq_nt_fetch", trace[6].addr, 8'h11);
    wait_halt("beq_nt_halt", 20);

    // JMP to 0xFF, then the pc wraps to 0x00.
    hold();
    mem[0]     = 16'hC0FF;
    mem[8'hFF] = enc_i(4'h8, 1, 1, 1);
    release_cpu();
    run(6);
    check("jmp_target", trace[2].addr, 8'hFF);
    check("jmp_wrap", trace[4].addr, 8'h00);

    // HALT at address 3.
    hold();
    mem[0] = 16'hE000;
    mem[1] = 16'hE000;
    mem[2] = 16'hE000;
    mem[3] = 16'hF000;
    release_cpu();
    run(12);
    check("halt_fetch_addr", trace[6].addr, 8'h03);
    check("halt_exec_low", trace[7].halt, 0);
    check("halt_set", trace[8].halt, 1);
    check("halt_addr", trace[8].addr, 8'h04);
    check("halt_rw", trace[8].rw, 1);
    check("halt_addr_stays", trace[11].addr, 8'h04);
    check("halt_stays", trace[11].halt, 1);
    #2;
    reset = 1'b0;
    #1;
    check("halt_async_clear", halted, 0);
    check("halt_reset_addr", address, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle SimpleCPU core. It fetches 16-bit instructions from a shared single-port memory and executes them through a FETCH/EXEC/MEM state machine. It adds immediates, loads, stores, branches, jumps and HALT, and generalises data width, address width and register count. It sits between the system clock/reset and the shared instruction/data memory, using the same memory port names as SimpleCPU.

## Interface
Parameters:
- DATA_W, 16: register, ALU and memory word width; minimum 16. Instructions occupy bits [15:0] of a word.
- ADDR_W, 8: memory address width; range 6..12.
- REG_N, 8: number of registers; 2..8, selected by 3-bit fields. Out-of-range indices read 0 and ignore writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_out  input  DATA_W  memory read data; combinational, valid in the same cycle `address` is presented.
- rw_enable  output  1  memory write enable, active low: 0 = write `data_in` to `address`, 1 = read.
- address  output  ADDR_W  memory address.
- data_in  output  DATA_W  memory write data.
- halted  output  1  high once HALT has executed.

## Operation
- Encoding: op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm6 = [5:0] (sign-extended), tgt = [ADDR_W-1:0].
- Register-register ops 0x0–0x7 compute rd = rs1 op rs2:
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR.
  - 0x5 SHL and 0x6 SHR (logical) use rs2[3:0] as the shift amount.
  - 0x7 SLT is a signed compare that returns 1 or 0.
- 0x8 ADDI: rd = rs1 + imm6.
- 0x9 LD: rd = mem[rs1 + imm6].
- 0xA ST: mem[rs1 + imm6] = rd.
- 0xB BEQ: if rd == rs1, pc = pc_of_instr + 1 + imm6.
- 0xC JMP: pc = tgt.
- 0xD MUL: see Configuration.
- 0xF HALT.
- 0xE and any disabled opcode execute as a NOP.
- Arithmetic is modulo 2^DATA_W. Effective addresses and branch targets are truncated to ADDR_W bits, so addresses wrap from 2^ADDR_W-1 to 0.
- Register r0 always reads 0; writes to r0 are discarded. Register reads are combinational.
- State machine:
  - FETCH: address = pc, rw_enable = 1. IR <= data_out, pc <= pc + 1. Next state is EXEC.
  - EXEC: ALU ops, ADDI and MUL write rd and go to FETCH. BEQ and JMP update pc and go to FETCH. LD and ST latch the effective address and go to MEM. HALT sets halted and goes to HLT. NOPs go to FETCH.
  - MEM: address = effective address. LD latches data_out into rd. ST drives rw_enable = 0 and data_in = rd for exactly this cycle. Next state is FETCH.
  - HLT: terminal state. address = pc, rw_enable = 1; leaves only on reset.
- data_in is 0 in every cycle except the ST MEM cycle.

## Timing
- Reset asserted (async, immediate):
  - state = FETCH, pc = 0, IR = 0, all registers = 0.
  - address = 0, rw_enable = 1, data_in = 0, halted = 0.
- Reset asserted during a ST MEM cycle forces rw_enable to 1 combinationally in the same cycle; no partial write is required to be suppressed beyond that.
- First fetch occurs in the first clock cycle after reset deasserts.
- Latency in cycles: ALU, ADDI, MUL, BEQ, JMP, NOP = 2; LD and ST = 3; HALT = 2, then halted stays high.
- A register written in EXEC or MEM is visible to the next instruction's EXEC, so there are no hazards.
- BEQ not taken costs the same 2 cycles as taken.
- Self-loop: JMP to its own address or BEQ with imm6 = -1 loops indefinitely.
- address and rw_enable are driven from registered state and the latched effective address; no combinational path from data_out to rw_enable.

## Configuration
- Macro: MULTICYCLE_CPU_MUL_EN.
- Defined: opcode 0xD is MUL, rd = low DATA_W bits of rs1 * rs2 (unsigned), completing in EXEC with 2-cycle latency.
- Undefined: 0xD is a NOP; no multiplier hardware is instantiated.

## Test plan
- Reset then release with mem[0] = 0x8205 (ADDI r1, r0, 5) and mem[1] = 0x8443 (ADDI r2, r1, 3) -> after 4 cycles r1 = 5, r2 = 8; address sequence 0, 0, 1, 1.
- ST/LD round trip with r1 = 0x00AB and base r2 = 0x40:
  - ST r1, 2(r2) -> single cycle with rw_enable = 0, address = 0x42, data_in = 0x00AB.
  - LD r3, 2(r2) -> r3 = 0x00AB; the LD takes 3 cycles.
- BEQ r1, r1, -1 at address 0x10 -> pc returns to 0x10 every 2 cycles. With unequal registers, the next fetch address is 0x11.
- JMP 0xFF followed by the instruction at 0xFF = ADDI -> the next fetch wraps to 0x00; ADDI 0x7FFF + 1 gives 0x8000 with no flag.
- HALT at address 3 -> halted = 1 two cycles after its fetch; address stays at 4 and rw_enable = 1. Async reset mid-HALT clears halted immediately.
- MUL r3 = r1 * r2 with r1 = 0x0100, r2 = 0x0101:
  - With MULTICYCLE_CPU_MUL_EN -> r3 = 0x0100 (low 16 bits).
  - Without the macro -> r3 unchanged and pc advances by 1.
